// File: rtl/apb_requester.sv
// APB3/APB4 initiator: one valid/ready command becomes one APB transfer with XOR-CRC insert/check.
// Optional ACCESS-phase watchdog enabled by defining APB_REQUESTER_WATCHDOG_EN.
module apb_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_crc_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic                  PWAKEUP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [2:0]            PPROT,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_e;

    state_e                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic                  pwakeup_q, pwakeup_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_crc_err_q, rsp_crc_err_d;

`ifdef APB_REQUESTER_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
`endif

    // Top byte carries the CRC, so only the lower STRB_WIDTH-1 bytes contribute.
    function automatic logic [7:0] crc_byte(input logic [DATA_WIDTH-1:0] x,
                                            input logic [STRB_WIDTH-1:0] s);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < STRB_WIDTH - 1; j++) begin
            if (s[j]) r = r ^ x[8*j +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pwakeup_d     = cmd_valid | (state_q != IDLE);
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_crc_err_d = rsp_crc_err_q;
`ifdef APB_REQUESTER_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = cmd_addr;
                    pprot_d   = cmd_prot;
                    pwrite_d  = cmd_write;
                    if (cmd_write) begin
                        pwdata_d = {crc_byte(cmd_wdata, cmd_strb), cmd_wdata[DATA_WIDTH-9:0]};
                        pstrb_d  = {1'b1, cmd_strb[STRB_WIDTH-2:0]};
                    end else begin
                        pwdata_d = '0;
                        pstrb_d  = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_REQUESTER_WATCHDOG_EN
                wd_cnt_d  = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
`ifdef APB_REQUESTER_WATCHDOG_EN
                    rsp_timeout_d = 1'b0;
`endif
                    if (pwrite_q) begin
                        rsp_rdata_d   = '0;
                        rsp_crc_err_d = 1'b0;
                    end else begin
                        rsp_rdata_d   = PRDATA;
                        rsp_crc_err_d = PRDATA[DATA_WIDTH-1 -: 8] != crc_byte(PRDATA, '1);
                    end
                end
`ifdef APB_REQUESTER_WATCHDOG_EN
                else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_crc_err_d = 1'b0;
                    rsp_rdata_d   = '0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwakeup_q     <= 1'b0;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_crc_err_q <= 1'b0;
`ifdef APB_REQUESTER_WATCHDOG_EN
            wd_cnt_q      <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwakeup_q     <= pwakeup_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_crc_err_q <= rsp_crc_err_d;
`ifdef APB_REQUESTER_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

`ifdef APB_REQUESTER_WATCHDOG_EN
    assign rsp_timeout = rsp_timeout_q;
    logic unused_inputs;
    assign unused_inputs = ^{cmd_wdata[DATA_WIDTH-1 -: 8], cmd_strb[STRB_WIDTH-1]};
`else
    assign rsp_timeout = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{cmd_wdata[DATA_WIDTH-1 -: 8], cmd_strb[STRB_WIDTH-1],
                             1'(TIMEOUT_CYCLES)};
`endif

    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWAKEUP     = pwakeup_q;
    assign PADDR       = paddr_q;
    assign PPROT       = pprot_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_crc_err = rsp_crc_err_q;

endmodule
